// File: rtl/vc_input_port_controller.sv
// Input-port controller for the wormhole VC router: per-IVC output-VC locks,
// downstream credit counters per output VC, and switch-allocation requests.

`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module vc_ivc_ctrl #(
   parameter int CN        = 5,
   parameter bit VA_BYPASS = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fifo_empty,
   input  logic [1:0]    flit_type,
   input  logic [CN-1:0] candidate_out_vc,
   input  logic [CN-1:0] sel_out_vc,
   input  logic          vc_granted,
   input  logic          sa_grant,
   input  logic [CN-1:0] cred_nz,
   output logic [CN-1:0] req_vc,
   output logic [CN-1:0] eff_vc,
   output logic [CN-1:0] out_vc,
   output logic          sa_req,
   output logic          fire,
   output logic          active,
   output logic          head_err,
   output logic          ghost_grant
);
   typedef enum logic {IDLE, ACTIVE} ivc_state_e;

   ivc_state_e    state_q, state_d;
   logic [CN-1:0] out_vc_q, out_vc_d;
   // Set once a flit of the current packet has left; a HEAD at the front before
   // that is the packet's own (not yet sent) head, not a missing tail.
   logic          started_q, started_d;
   logic          is_tail;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         out_vc_q  <= '0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_vc_q  <= out_vc_d;
         started_q <= started_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      out_vc_d  = out_vc_q;
      started_d = started_q;
      eff_vc    = '0;
      req_vc    = '0;
      is_tail   = (flit_type == `TAIL);

      if (state_q == ACTIVE)
         eff_vc = out_vc_q;
      else if (VA_BYPASS && vc_granted)
         eff_vc = sel_out_vc;
      if (rst)
         eff_vc = '0;

      if (!rst && state_q == IDLE && !fifo_empty && flit_type == `HEAD)
         req_vc = candidate_out_vc;

      sa_req      = (|eff_vc) && !fifo_empty && (|(eff_vc & cred_nz));
      fire        = sa_grant && sa_req;
      ghost_grant = sa_grant && !sa_req;

      case (state_q)
         IDLE: begin
            // a tail that fires in its own grant cycle never takes the lock
            if (vc_granted && !(fire && is_tail)) begin
               state_d   = ACTIVE;
               out_vc_d  = sel_out_vc;
               started_d = fire;
            end
         end
         ACTIVE: begin
            if (fire)
               started_d = 1'b1;
            if (fire && is_tail) begin
               state_d   = IDLE;
               out_vc_d  = '0;
               started_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      active   = (state_q == ACTIVE);
      out_vc   = out_vc_q;
      head_err = active && started_q && !fifo_empty && (flit_type == `HEAD);
   end
endmodule

module vc_input_port_controller #(
   parameter int NUM_IVC   = 2,
   parameter int CN        = 5,
   parameter int BUF_DEPTH = 4,
   parameter int CRED_W    = $clog2(BUF_DEPTH + 1),
   parameter int VA_BYPASS = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IVC-1:0]      fifo_empty,
   input  logic [2*NUM_IVC-1:0]    flit_type,
   input  logic [CN*NUM_IVC-1:0]   candidate_out_vc,
   output logic [CN*NUM_IVC-1:0]   req_vc,
   input  logic [CN*NUM_IVC-1:0]   sel_out_vc,
   input  logic [NUM_IVC-1:0]      vc_granted,
   output logic [NUM_IVC-1:0]      sa_req,
   input  logic [NUM_IVC-1:0]      sa_grant,
   output logic [CN*NUM_IVC-1:0]   sel_xb_vc,
   input  logic [CN-1:0]           credit_in,
   output logic [CRED_W*CN-1:0]    credit_cnt,
   output logic                    proto_err
);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_DEPTH);

   logic [NUM_IVC-1:0][CN-1:0]  eff, ovc, req_pk;
   logic [NUM_IVC-1:0]          fire, active, head_err, ghost;
   logic [CN-1:0][CRED_W-1:0]   cnt_q;
   logic [CN-1:0]               cred_nz, dec, sat;
   logic                        overlap;
   logic                        err_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IVC; gi++) begin : g_ivc
         vc_ivc_ctrl #(.CN(CN), .VA_BYPASS(VA_BYPASS != 0)) u_ivc (
            .clk              (clk),
            .rst              (rst),
            .fifo_empty       (fifo_empty[gi]),
            .flit_type        (flit_type[2*gi +: 2]),
            .candidate_out_vc (candidate_out_vc[CN*gi +: CN]),
            .sel_out_vc       (sel_out_vc[CN*gi +: CN]),
            .vc_granted       (vc_granted[gi]),
            .sa_grant         (sa_grant[gi]),
            .cred_nz          (cred_nz),
            .req_vc           (req_pk[gi]),
            .eff_vc           (eff[gi]),
            .out_vc           (ovc[gi]),
            .sa_req           (sa_req[gi]),
            .fire             (fire[gi]),
            .active           (active[gi]),
            .head_err         (head_err[gi]),
            .ghost_grant      (ghost[gi])
         );
      end
   endgenerate

   assign req_vc     = req_pk;
   assign sel_xb_vc  = eff;
   assign credit_cnt = cnt_q;
   assign proto_err  = err_q;

   always_comb begin
      dec     = '0;
      overlap = 1'b0;
      for (int v = 0; v < CN; v++)
         cred_nz[v] = (cnt_q[v] != '0);
      for (int i = 0; i < NUM_IVC; i++) begin
         if (fire[i])
            dec = dec | eff[i];
         for (int j = i + 1; j < NUM_IVC; j++)
            if (active[i] && active[j] && |(ovc[i] & ovc[j]))
               overlap = 1'b1;
      end
      for (int v = 0; v < CN; v++)
         sat[v] = credit_in[v] && !dec[v] && (cnt_q[v] == CRED_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < CN; v++)
            cnt_q[v] <= CRED_MAX;
         err_q <= 1'b0;
      end else begin
         for (int v = 0; v < CN; v++) begin
            if (dec[v] && !credit_in[v])
               cnt_q[v] <= cnt_q[v] - CRED_W'(1);
            else if (credit_in[v] && !dec[v] && !sat[v])
               cnt_q[v] <= cnt_q[v] + CRED_W'(1);
         end
         err_q <= err_q | (|sat) | (|head_err) | (|ghost) | overlap;
      end
   end
endmodule
